// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encodings and field widths.
// The same encodings are used by the pipeline top and its bench.
package pipe_hazard_ctrl_pkg;

    localparam int REG_NUM_W  = 5;
    localparam int BUB_CNT_W  = 2;
    localparam int TO_CNT_W   = 8;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // Folds an unused encoding back to RUN so a corrupted state self-recovers.
    function automatic hz_state_e legal_state(input hz_state_e s);
        case (s)
            LU_STALL: legal_state = LU_STALL;
            MEM_WAIT: legal_state = MEM_WAIT;
            default:  legal_state = RUN;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: ID source operands against the destination of a load in EXE.
// Register 0 is never a real dependency.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_NUM_W-1:0] id_rs,
    input  logic [REG_NUM_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 exe_load,
    input  logic [REG_NUM_W-1:0] exe_num_write,
    output logic                 hazard
);

    logic rs_match;
    logic rt_match;
    logic dest_live;

    always_comb begin
        rs_match  = id_uses_rs && (id_rs == exe_num_write);
        rt_match  = id_uses_rt && (id_rt == exe_num_write);
        dest_live = exe_load && (exe_num_write != '0);
        hazard    = dest_live && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch/jump flushes and
// memory-wait freeze with timeout abort. Define HAZ_PERF_EN to add stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_NUM_W-1:0]  id_rs,
    input  logic [REG_NUM_W-1:0]  id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic                  exe_load,
    input  logic [REG_NUM_W-1:0]  exe_num_write,
    input  logic                  exe_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  ifid_flush,
    output logic                  idexe_hold,
    output logic                  idexe_flush,
    output logic                  exmem_hold,
    output logic                  mem_err,
`ifdef HAZ_PERF_EN
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]            state_dbg
);

    localparam logic [BUB_CNT_W-1:0] BUB_INIT = BUB_CNT_W'(LOAD_BUBBLES - 1);
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(MEM_TIMEOUT - 1);

    hz_state_e              state_q, state_d;
    hz_state_e              ret_q, ret_d;
    hz_state_e              eff_state;
    logic [BUB_CNT_W-1:0]   bub_cnt_q, bub_cnt_d;
    logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;
    logic                   mem_err_q, mem_err_d;
    logic                   hazard;
    logic                   waiting;

    load_use_detect u_load_use_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .exe_load      (exe_load),
        .exe_num_write (exe_num_write),
        .hazard        (hazard)
    );

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idexe_hold  = 1'b0;
        idexe_flush = 1'b0;
        exmem_hold  = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        bub_cnt_d   = bub_cnt_q;
        to_cnt_d    = to_cnt_q;
        mem_err_d   = 1'b0;

        // While frozen on memory the cycle is judged as the state that was interrupted.
        eff_state = (state_q == MEM_WAIT) ? legal_state(ret_q) : legal_state(state_q);
        // The abort cycle releases the pipe even if the memory is still not ready.
        waiting   = mem_req && !mem_ready && !mem_err_q;

        if (waiting) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idexe_hold = 1'b1;
            exmem_hold = 1'b1;
            if (to_cnt_q == TO_LAST) begin
                mem_err_d = 1'b1;
                state_d   = RUN;
                ret_d     = RUN;
                bub_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                state_d  = MEM_WAIT;
                ret_d    = eff_state;
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
            state_d  = eff_state;
            ret_d    = RUN;
            if (exe_branch_taken) begin
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
                state_d     = RUN;
                bub_cnt_d   = '0;
            end else if (eff_state == LU_STALL) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idexe_flush = 1'b1;
                if (bub_cnt_q <= BUB_CNT_W'(1)) begin
                    state_d   = RUN;
                    bub_cnt_d = '0;
                end else begin
                    bub_cnt_d = bub_cnt_q - 1'b1;
                end
            end else if (hazard) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idexe_flush = 1'b1;
                if (LOAD_BUBBLES > 1) begin
                    state_d   = LU_STALL;
                    bub_cnt_d = BUB_INIT;
                end
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            bub_cnt_q <= '0;
            to_cnt_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            bub_cnt_q <= bub_cnt_d;
            to_cnt_q  <= to_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign state_dbg = state_q;

`ifdef HAZ_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + PERF_CNT_W'(pc_hold);
        flush_cnt_d = flush_cnt_q + PERF_CNT_W'(ifid_flush || idexe_flush);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    a_ifid_excl: assert property (@(posedge clock) disable iff (!reset) !(ifid_hold && ifid_flush));
    a_idexe_excl: assert property (@(posedge clock) disable iff (!reset) !(idexe_hold && idexe_flush));

endmodule
